display_sequencer: RTL and testbench

DISPLAY_SEQUENCER -- requirements
Module: display_sequencer

---
 rtl/display_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_display_sequencer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/display_sequencer.sv
// rtl/display_sequencer.sv - binary/hex to multiplexed 8-digit display sequencer
//
// Purpose: watches value_in/hex_mode, converts a changed value to decimal
// (double-dabble) or hex digits, commits them to eight display digit
// registers, and scans those digits one at a time onto an active-low
// anode bus.
//
// Ports:
//   clk           system clock, rising edge
//   reset         asynchronous, active-low reset
//   value_in      16-bit binary value to display
//   hex_mode      1 = hexadecimal display, 0 = decimal display
//   an            active-low digit enables, at most one bit low
//   digit_code    code of the currently enabled digit
//   busy          high while a conversion is in progress
//   update_pulse  one-cycle pulse when the digit registers are rewritten

module display_sequencer #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int DIGIT_HZ = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] value_in,
    input  logic        hex_mode,
    output logic [7:0]  an,
    output logic [3:0]  digit_code,
    output logic        busy,
    output logic        update_pulse
);

    localparam int DIV = CLK_FREQ / DIGIT_HZ;
    localparam int PW  = $clog2(DIV);
    localparam logic [PW-1:0] PS_LAST = PW'(DIV - 1);

    typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} state_t;

    state_t          state;
    state_t          state_next;
    logic            capture;

    logic [15:0]     sh_value;
    logic            sh_mode;
    logic [19:0]     bcd;
    logic [15:0]     bin;
    logic [3:0]      step;
    logic [19:0]     bcd_adj;
    logic [35:0]     dabble_shift;

    logic [7:0][3:0] digits;
    logic            disp_hex;

    logic [PW-1:0]   psc;
    logic [2:0]      idx;
    logic [7:0]      tail_nz;
    logic            blank;

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state logic; capture marks the edge the shadows are loaded
    always_comb begin
        state_next = state;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (value_in != sh_value || hex_mode != sh_mode) begin
                    capture    = 1'b1;
                    state_next = hex_mode ? COMMIT : CONVERT;
                end
            end
            CONVERT: begin
                if (step == 4'd15) begin
                    state_next = COMMIT;
                end
            end
            COMMIT: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Double-dabble correction: any BCD nibble >= 5 gets +3 before the shift
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < 5; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    assign dabble_shift = {bcd_adj, bin} << 1;

    // Conversion datapath and digit commit
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sh_value     <= '0;
            sh_mode      <= 1'b0;
            bcd          <= '0;
            bin          <= '0;
            step         <= '0;
            digits       <= '0;
            disp_hex     <= 1'b0;
            update_pulse <= 1'b0;
        end else begin
            update_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (capture) begin
                        sh_value <= value_in;
                        sh_mode  <= hex_mode;
                        bin      <= value_in;
                        bcd      <= '0;
                        step     <= '0;
                    end
                end
                CONVERT: begin
                    bcd  <= dabble_shift[35:16];
                    bin  <= dabble_shift[15:0];
                    step <= step + 4'd1;
                end
                COMMIT: begin
                    update_pulse <= 1'b1;
                    disp_hex     <= sh_mode;
                    if (sh_mode) begin
                        digits <= {16'h0000, sh_value};
                    end else begin
                        digits <= {12'h000, bcd};
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy = (state != IDLE);

    // tail_nz[i] is set when any committed digit from i up to 7 is nonzero,
    // which is exactly the leading-zero test for decimal blanking
    always_comb begin
        tail_nz    = '0;
        tail_nz[7] = |digits[7];
        for (int i = 6; i >= 0; i--) begin
            tail_nz[i] = tail_nz[i+1] | (|digits[i]);
        end
        if (disp_hex) begin
            blank = idx[2];
        end else begin
            blank = (idx != 3'd0) && !tail_nz[idx];
        end
    end

    // Free-running scan; never disturbed by conversions
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            psc        <= '0;
            idx        <= '0;
            an         <= 8'hFE;
            digit_code <= '0;
        end else begin
            if (psc == PS_LAST) begin
                psc <= '0;
                idx <= idx + 3'd1;
            end else begin
                psc <= psc + 1'b1;
            end
            if (blank) begin
                an         <= 8'hFF;
                digit_code <= '0;
            end else begin
                an         <= ~(8'd1 << idx);
                digit_code <= digits[idx];
            end
        end
    end

endmodule

// File: tb/tb_display_sequencer.sv
// tb/tb_display_sequencer.sv - self-checking bench for display_sequencer

module tb_display_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] value_in;
    logic        hex_mode;
    logic [7:0]  an;
    logic [3:0]  digit_code;
    logic        busy;
    logic        update_pulse;

    display_sequencer #(
        .CLK_FREQ(8),
        .DIGIT_HZ(1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .value_in    (value_in),
        .hex_mode    (hex_mode),
        .an          (an),
        .digit_code  (digit_code),
        .busy        (busy),
        .update_pulse(update_pulse)
    );

    always #5 clk = ~clk;

    int vectors;
    int miscompares;
    int pulses;
    int busy_cycles;

    // Reference model: scan position, pending-commit countdown,
    // and the value/mode currently on the display
    int          m_psc;
    int          m_idx;
    logic [15:0] m_sh_v;
    logic        m_sh_m;
    int          m_left;
    int          m_val;
    logic        m_hex;
    logic [7:0]  e_an;
    logic [3:0]  e_code;
    logic        e_pulse;

    function automatic int pow10(input int k);
        int r = 1;
        for (int i = 0; i < k; i++) r = r * 10;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_psc   = 0;
        m_idx   = 0;
        m_sh_v  = '0;
        m_sh_m  = 1'b0;
        m_left  = 0;
        m_val   = 0;
        m_hex   = 1'b0;
        e_an    = 8'hFE;
        e_code  = 4'h0;
        e_pulse = 1'b0;
    endtask

    task automatic cycle();
        bit shown;
        @(posedge clk);
        if (reset) begin
            if (m_hex) shown = (m_idx < 4);
            else       shown = (m_idx == 0) || (m_val >= pow10(m_idx));
            if (shown) begin
                e_an = ~(8'd1 << m_idx);
                if (m_hex) e_code = 4'((m_val >> (4 * m_idx)) & 15);
                else       e_code = 4'((m_val / pow10(m_idx)) % 10);
            end else begin
                e_an   = 8'hFF;
                e_code = 4'h0;
            end
            m_psc++;
            if (m_psc == 8) begin
                m_psc = 0;
                m_idx = (m_idx + 1) % 8;
            end
            e_pulse = 1'b0;
            if (m_left == 0) begin
                if (value_in !== m_sh_v || hex_mode !== m_sh_m) begin
                    m_sh_v = value_in;
                    m_sh_m = hex_mode;
                    m_left = hex_mode ? 1 : 17;
                end
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_val   = int'(m_sh_v);
                    m_hex   = m_sh_m;
                    e_pulse = 1'b1;
                end
            end
        end
        #1;
        chk("an", an, e_an);
        chk("digit_code", digit_code, e_code);
        chk("busy", busy, (m_left != 0));
        chk("update_pulse", update_pulse, e_pulse);
        if (update_pulse) pulses++;
        if (busy) busy_cycles++;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_reset();
        #1;
        chk("rst_an", an, 8'hFE);
        chk("rst_digit_code", digit_code, 4'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_update_pulse", update_pulse, 1'b0);
    endtask

    int lat;

    initial begin
        vectors     = 0;
        miscompares = 0;
        pulses      = 0;
        busy_cycles = 0;
        reset       = 1'b1;
        value_in    = 16'h0000;
        hex_mode    = 1'b0;
        #2;
        do_reset();
        repeat (2) cycle();
        reset = 1'b1;

        // V-1: idle with zero value, only digit 0 lit
        busy_cycles = 0;
        repeat (72) cycle();
        chk("v1_busy_cycles", busy_cycles, 0);

        // V-2: 65535 decimal
        busy_cycles = 0;
        pulses      = 0;
        value_in    = 16'hFFFF;
        repeat (30) cycle();
        chk("v2_busy_cycles", busy_cycles, 17);
        chk("v2_pulses", pulses, 1);
        repeat (64) cycle();

        // V-3: hex BEEF, commit one cycle after capture
        hex_mode = 1'b1;
        value_in = 16'hBEEF;
        lat = 0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            lat++;
            if (update_pulse) break;
        end
        chk("v3_latency", lat, 2);
        repeat (64) cycle();

        // V-4: leading-zero blanking
        hex_mode = 1'b0;
        value_in = 16'd9;
        repeat (84) cycle();
        value_in = 16'd100;
        repeat (84) cycle();

        // V-5: input change during conversion is deferred
        pulses   = 0;
        value_in = 16'd1234;
        cycle();
        repeat (5) cycle();
        value_in = 16'd4321;
        repeat (60) cycle();
        chk("v5_pulses", pulses, 2);
        repeat (64) cycle();

        // Randomized values, modes and mid-conversion changes
        for (int r = 0; r < 12; r++) begin
            value_in = 16'($urandom);
            hex_mode = 1'($urandom);
            repeat ($urandom_range(1, 24)) cycle();
            if ($urandom_range(0, 1) == 1) value_in = 16'($urandom);
            repeat (40) cycle();
            repeat ($urandom_range(0, 30)) cycle();
        end
        hex_mode = 1'b0;
        value_in = 16'd0;
        repeat (40) cycle();

        // V-6: reset mid-conversion aborts, then a fresh conversion runs
        value_in = 16'd65535;
        cycle();
        repeat (8) cycle();
        pulses = 0;
        do_reset();
        repeat (3) cycle();
        chk("v6_pulses_in_reset", pulses, 0);
        reset = 1'b1;
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            cycle();
            lat++;
            if (update_pulse) break;
        end
        chk("v6_latency", lat, 18);
        repeat (64) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
